// File: rtl/card_overlay.sv
// ============================================================================
// Module      : card_overlay
// Description : Composites one movable card sprite over the background RGB
//               stream. Texels come from an external synchronous ROM, and a
//               key colour is treated as transparent. Position updates are
//               double-buffered and take effect only at frame start. Output
//               latency is a fixed two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_overlay #(
    parameter int          CARD_W     = 64,
    parameter int          CARD_H     = 96,
    parameter int          ROM_AW     = 13,
    parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
    input  logic              i_clk_25M,
    input  logic              i_rst_n,
    input  logic [9:0]        i_x_cnt,
    input  logic [9:0]        i_y_cnt,
    input  logic              i_frame_start,
    input  logic [7:0]        i_bg_r,
    input  logic [7:0]        i_bg_g,
    input  logic [7:0]        i_bg_b,
    input  logic              i_pos_valid,
    input  logic [9:0]        i_pos_x,
    input  logic [9:0]        i_pos_y,
    input  logic              i_pos_en,
    output logic              o_pos_ready,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_data,
    output logic [7:0]        o_r,
    output logic [7:0]        o_g,
    output logic [7:0]        o_b,
    output logic              o_busy
);

    // Column offset occupies the low address bits, row offset the rest,
    // so the row multiply by CARD_W is just a concatenation.
    localparam int          c_XW  = $clog2(CARD_W);
    localparam int          c_YW  = ROM_AW - c_XW;
    localparam logic [10:0] c_W11 = 11'(CARD_W);
    localparam logic [10:0] c_H11 = 11'(CARD_H);

    // Active (displayed) card position and visibility
    logic [9:0]  r_act_x;
    logic [9:0]  r_act_y;
    logic        r_act_en;

    // Pending update, waiting for the next frame start
    logic        r_pend_full;
    logic [9:0]  r_pend_x;
    logic [9:0]  r_pend_y;
    logic        r_pend_en;

    // Pipeline stage 1 and output stage
    logic        r_hit_d;
    logic [23:0] r_bg_d;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;

    logic [10:0]     w_x11;
    logic [10:0]     w_y11;
    logic [10:0]     w_px11;
    logic [10:0]     w_py11;
    logic            w_hit;
    logic [c_XW-1:0] w_dx;
    logic [c_YW-1:0] w_dy;
    logic            w_accept;
    logic            w_commit;
    logic            w_draw;

    // Extend to 11 bits so px+CARD_W cannot wrap back into the visible range
    assign w_x11  = {1'b0, i_x_cnt};
    assign w_y11  = {1'b0, i_y_cnt};
    assign w_px11 = {1'b0, r_act_x};
    assign w_py11 = {1'b0, r_act_y};

    assign w_hit = r_act_en
                && (w_x11 >= w_px11) && (w_x11 < (w_px11 + c_W11))
                && (w_y11 >= w_py11) && (w_y11 < (w_py11 + c_H11));

    // Offsets only matter when hit, where they fit their truncated widths
    assign w_dx = c_XW'(i_x_cnt - r_act_x);
    assign w_dy = c_YW'(i_y_cnt - r_act_y);

    assign o_rom_addr = w_hit ? {w_dy, w_dx} : '0;

    // Accept and commit are mutually exclusive: one needs the buffer empty,
    // the other needs it full. A request landing on a frame-start cycle
    // therefore waits for the following frame start.
    assign w_accept = i_pos_valid && !r_pend_full;
    assign w_commit = i_frame_start && r_pend_full;

    assign o_pos_ready = ~r_pend_full;
    assign o_busy      = r_pend_full;

    // Pending buffer fill/drain and active-position commit at frame start
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_act_en    <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_en   <= 1'b0;
        end else if (w_commit) begin
            r_act_x     <= r_pend_x;
            r_act_y     <= r_pend_y;
            r_act_en    <= r_pend_en;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend_x    <= i_pos_x;
            r_pend_y    <= i_pos_y;
            r_pend_en   <= i_pos_en;
            r_pend_full <= 1'b1;
        end
    end

    // Stage 1: delay hit and background to line up with the ROM read data
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_d <= 1'b0;
            r_bg_d  <= '0;
        end else begin
            r_hit_d <= w_hit;
            r_bg_d  <= {i_bg_r, i_bg_g, i_bg_b};
        end
    end

    assign w_draw = r_hit_d && (i_rom_data != TRANSP_KEY);

    // Stage 2: select sprite texel or background into the output register
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (w_draw) begin
            {r_r, r_g, r_b} <= i_rom_data;
        end else begin
            {r_r, r_g, r_b} <= r_bg_d;
        end
    end

    assign o_r = r_r;
    assign o_g = r_g;
    assign o_b = r_b;

endmodule

`default_nettype wire

// File: tb/tb_card_overlay.sv
// ============================================================================
// Module      : tb_card_overlay
// Description : Directed self-checking bench for card_overlay. Each scenario
//               drives pixels and compares the ROM address combinationally
//               and the composited pixel two clock edges later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_overlay;

    logic        clk;
    logic        rst_n;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic        frame_start;
    logic [7:0]  bg_r;
    logic [7:0]  bg_g;
    logic [7:0]  bg_b;
    logic        pos_valid;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        pos_en;
    logic        pos_ready;
    logic [12:0] rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
    logic        busy;

    int tests;
    int fails;

    card_overlay #(
        .CARD_W(64), .CARD_H(96), .ROM_AW(13), .TRANSP_KEY(24'hFF00FF)
    ) dut (
        .i_clk_25M    (clk),
        .i_rst_n      (rst_n),
        .i_x_cnt      (x_cnt),
        .i_y_cnt      (y_cnt),
        .i_frame_start(frame_start),
        .i_bg_r       (bg_r),
        .i_bg_g       (bg_g),
        .i_bg_b       (bg_b),
        .i_pos_valid  (pos_valid),
        .i_pos_x      (pos_x),
        .i_pos_y      (pos_y),
        .i_pos_en     (pos_en),
        .o_pos_ready  (pos_ready),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_r          (out_r),
        .o_g          (out_g),
        .o_b          (out_b),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request a position (buffer assumed empty) and commit it with frame_start
    task automatic load_pos(input logic [9:0] px, input logic [9:0] py, input logic en);
        pos_x = px; pos_y = py; pos_en = en; pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x_cnt = 10'd5; y_cnt = 10'd5;
        {bg_r, bg_g, bg_b} = 24'h202020;
        rom_data = 24'h123456;
        frame_start = 1'b0; pos_valid = 1'b0;
        pos_x = '0; pos_y = '0; pos_en = 1'b0;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h0) begin fails++; $display("FAIL reset_rgb got %h exp 000000", {out_r, out_g, out_b}); end
        tests++; if (pos_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", pos_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
        rst_n = 1'b1;
        step();
        tests++; if ({out_r, out_g, out_b} !== 24'h0) begin fails++; $display("FAIL reset_lat1 got %h exp 000000", {out_r, out_g, out_b}); end
        step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL reset_bg got %h exp 202020", {out_r, out_g, out_b}); end
    endtask

    // Back-to-back pixels along y=50 around the left edge of a card at (100,50)
    task automatic test_sweep();
        logic [9:0]  xs [3];
        logic [12:0] ea [3];
        logic [23:0] eo [3];
        xs = '{10'd99, 10'd100, 10'd101};
        ea = '{13'd0, 13'd0, 13'd1};
        eo = '{24'h202020, 24'h123456, 24'h123456};
        load_pos(10'd100, 10'd50, 1'b1);
        tests++; if (pos_ready !== 1'b1) begin fails++; $display("FAIL sweep_ready got %b exp 1", pos_ready); end
        rom_data = 24'h123456;
        {bg_r, bg_g, bg_b} = 24'h202020;
        y_cnt = 10'd50;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) begin
                tests++;
                if ({out_r, out_g, out_b} !== eo[k-2]) begin
                    fails++; $display("FAIL sweep_rgb[%0d] got %h exp %h", k-2, {out_r, out_g, out_b}, eo[k-2]);
                end
            end
            if (k < 3) begin
                x_cnt = xs[k];
                #1;
                tests++;
                if (rom_addr !== ea[k]) begin
                    fails++; $display("FAIL sweep_addr[%0d] got %0d exp %0d", k, rom_addr, ea[k]);
                end
            end
            step();
        end
    endtask

    // Bottom-right corner of the card at (100,50) and one pixel past it
    task automatic test_corner();
        rom_data = 24'hABCDEF;
        {bg_r, bg_g, bg_b} = 24'h202020;
        x_cnt = 10'd163; y_cnt = 10'd145; #1;
        tests++; if (rom_addr !== 13'd6143) begin fails++; $display("FAIL corner_addr got %0d exp 6143", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'hABCDEF) begin fails++; $display("FAIL corner_rgb got %h exp abcdef", {out_r, out_g, out_b}); end
        x_cnt = 10'd164; y_cnt = 10'd145; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL right_addr got %0d exp 0", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL right_rgb got %h exp 202020", {out_r, out_g, out_b}); end
        x_cnt = 10'd163; y_cnt = 10'd146; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL below_addr got %0d exp 0", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL below_rgb got %h exp 202020", {out_r, out_g, out_b}); end
    endtask

    // Key colour lets the background through; a near-key colour is drawn
    task automatic test_transparent();
        {bg_r, bg_g, bg_b} = 24'h112233;
        rom_data = 24'hFF00FF;
        x_cnt = 10'd120; y_cnt = 10'd60; #1;
        tests++; if (rom_addr !== 13'd660) begin fails++; $display("FAIL transp_addr got %0d exp 660", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h112233) begin fails++; $display("FAIL transp_rgb got %h exp 112233", {out_r, out_g, out_b}); end
        rom_data = 24'hFF00FE;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'hFF00FE) begin fails++; $display("FAIL nearkey_rgb got %h exp ff00fe", {out_r, out_g, out_b}); end
    endtask

    // Mid-frame request: old card stays until frame_start, second request ignored
    task automatic test_update();
        {bg_r, bg_g, bg_b} = 24'h202020;
        rom_data = 24'h123456;
        pos_x = 10'd200; pos_y = 10'd10; pos_en = 1'b1; pos_valid = 1'b1;
        step();
        tests++; if (pos_ready !== 1'b0) begin fails++; $display("FAIL upd_ready got %b exp 0", pos_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL upd_busy got %b exp 1", busy); end
        pos_x = 10'd300; pos_y = 10'd300;
        step(); step();
        pos_valid = 1'b0;
        x_cnt = 10'd100; y_cnt = 10'd50;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h123456) begin fails++; $display("FAIL upd_old_rgb got %h exp 123456", {out_r, out_g, out_b}); end
        x_cnt = 10'd200; y_cnt = 10'd10;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL upd_new_early got %h exp 202020", {out_r, out_g, out_b}); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        tests++; if (pos_ready !== 1'b1) begin fails++; $display("FAIL upd_ready_after got %b exp 1", pos_ready); end
        x_cnt = 10'd201; y_cnt = 10'd11; #1;
        tests++; if (rom_addr !== 13'd65) begin fails++; $display("FAIL upd_addr got %0d exp 65", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h123456) begin fails++; $display("FAIL upd_new_rgb got %h exp 123456", {out_r, out_g, out_b}); end
        x_cnt = 10'd100; y_cnt = 10'd50;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL upd_old_gone got %h exp 202020", {out_r, out_g, out_b}); end
        x_cnt = 10'd301; y_cnt = 10'd301; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL upd_ignored_addr got %0d exp 0", rom_addr); end
    endtask

    // Request on the frame_start cycle waits for the following frame_start
    task automatic test_simultaneous();
        rom_data = 24'h123456;
        pos_x = 10'd400; pos_y = 10'd100; pos_en = 1'b1;
        pos_valid = 1'b1; frame_start = 1'b1;
        step();
        pos_valid = 1'b0; frame_start = 1'b0;
        tests++; if (pos_ready !== 1'b0) begin fails++; $display("FAIL sim_ready got %b exp 0", pos_ready); end
        x_cnt = 10'd201; y_cnt = 10'd11; #1;
        tests++; if (rom_addr !== 13'd65) begin fails++; $display("FAIL sim_old_addr got %0d exp 65", rom_addr); end
        x_cnt = 10'd401; y_cnt = 10'd100; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL sim_new_early got %0d exp 0", rom_addr); end
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        tests++; if (pos_ready !== 1'b1) begin fails++; $display("FAIL sim_ready_after got %b exp 1", pos_ready); end
        #1;
        tests++; if (rom_addr !== 13'd1) begin fails++; $display("FAIL sim_new_addr got %0d exp 1", rom_addr); end
    endtask

    // Card near the right edge: no wrap of the hit window back to x=0
    task automatic test_edge_x();
        {bg_r, bg_g, bg_b} = 24'h202020;
        rom_data = 24'h0A0B0C;
        load_pos(10'd620, 10'd100, 1'b1);
        x_cnt = 10'd639; y_cnt = 10'd100; #1;
        tests++; if (rom_addr !== 13'd19) begin fails++; $display("FAIL edge_addr got %0d exp 19", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h0A0B0C) begin fails++; $display("FAIL edge_rgb got %h exp 0a0b0c", {out_r, out_g, out_b}); end
        x_cnt = 10'd0; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL nowrap_addr got %0d exp 0", rom_addr); end
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL nowrap_rgb got %h exp 202020", {out_r, out_g, out_b}); end
    endtask

    // Asynchronous reset mid-line clears outputs, active card and pending update
    task automatic test_reset_mid();
        rom_data = 24'h0A0B0C;
        pos_x = 10'd10; pos_y = 10'd10; pos_en = 1'b1; pos_valid = 1'b1;
        x_cnt = 10'd639; y_cnt = 10'd100;
        step();
        pos_valid = 1'b0;
        step();
        tests++; if ({out_r, out_g, out_b} !== 24'h0A0B0C) begin fails++; $display("FAIL rmid_pre got %h exp 0a0b0c", {out_r, out_g, out_b}); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_pre_busy got %b exp 1", busy); end
        #5 rst_n = 1'b0;
        #1;
        tests++; if ({out_r, out_g, out_b} !== 24'h0) begin fails++; $display("FAIL rmid_rgb got %h exp 000000", {out_r, out_g, out_b}); end
        tests++; if (pos_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b exp 1", pos_ready); end
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL rmid_addr got %0d exp 0", rom_addr); end
        step();
        rst_n = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        x_cnt = 10'd10; y_cnt = 10'd10; #1;
        tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL rmid_discard_addr got %0d exp 0", rom_addr); end
        {bg_r, bg_g, bg_b} = 24'h202020;
        step(); step();
        tests++; if ({out_r, out_g, out_b} !== 24'h202020) begin fails++; $display("FAIL rmid_discard_rgb got %h exp 202020", {out_r, out_g, out_b}); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_sweep();
        test_corner();
        test_transparent();
        test_update();
        test_simultaneous();
        test_edge_x();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/card_overlay.md
Name: card_overlay

Overview:
- Pixel-pipeline stage between the background generator and the VGA output driver.
- Composites one movable card sprite over the background RGB stream.
- Fetches sprite texels from an external synchronous ROM and treats a key colour as transparent.
- Position updates are double-buffered and committed only at frame start, so a card never tears mid-frame.

Parameters:
CARD_W, 64, sprite width in pixels; must be a power of 2
CARD_H, 96, sprite height in pixels
ROM_AW, 13, ROM address width; must satisfy 2^ROM_AW >= CARD_W*CARD_H
TRANSP_KEY, 24'hFF00FF, {R,G,B} texel value rendered as transparent

Ports:
i_clk_25M  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_x_cnt  in  10  current pixel column from the timing generator
i_y_cnt  in  10  current pixel row from the timing generator
i_frame_start  in  1  one-cycle pulse at start of vertical blank
i_bg_r / i_bg_g / i_bg_b  in  8 each  background pixel for (i_x_cnt, i_y_cnt)
i_pos_valid  in  1  new position request
i_pos_x  in  10  requested card left column
i_pos_y  in  10  requested card top row
i_pos_en  in  1  requested visibility
o_pos_ready  out  1  pending buffer empty; request accepted when valid&&ready
o_rom_addr  out  ROM_AW  texel address; ROM returns data one cycle later
i_rom_data  in  24  {R,G,B} texel from ROM
o_r / o_g / o_b  out  8 each  composited pixel
o_busy  out  1  pending update awaiting commit (equals ~o_pos_ready)

Behaviour:
- Clock/reset: one clock, i_clk_25M. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - Active position (0,0); active enable 0.
  - Pending buffer empty; o_pos_ready=1; o_busy=0.
  - o_r/o_g/o_b=0; internal pipeline registers 0.
- Hit test (combinational on cycle t inputs):
  - hit = act_en && x>=px && x<px+CARD_W && y>=py && y<py+CARD_H.
  - Evaluated in 11-bit unsigned arithmetic; no wrap.
- Address (combinational on cycle t inputs):
  - o_rom_addr = (y-py)*CARD_W + (x-px), formed as a bit concatenation; 0 when not hit.
- Clipping: cards with px+CARD_W>640 or py+CARD_H>480 are simply clipped. No special logic.
- Pipeline:
  - Edge t+1 registers: hit_d, bg_d.
  - ROM data for cycle t is valid during cycle t+1.
  - Edge t+2 registers outputs:
    - hit_d && i_rom_data!=TRANSP_KEY: output = i_rom_data.
    - otherwise: output = bg_d.
  - Total latency is 2 cycles, fixed and constant, including during blanking. The downstream stage compensates.
- Update handshake:
  - Accept when i_pos_valid && o_pos_ready: latch {x,y,en} into pending; o_pos_ready=0 from the next cycle.
  - i_pos_valid while o_pos_ready=0 is ignored. The requester must hold the request.
  - i_frame_start with pending full: copy pending to active on that edge; o_pos_ready=1 next cycle.
  - i_frame_start with pending empty: no effect.
  - Simultaneous accept and i_frame_start (pending empty): value enters pending and commits at the next i_frame_start, not this one.
- Active position never changes except at an i_frame_start edge or at reset.
- Reset mid-frame: outputs go to 0 immediately. Any pending update is discarded.

Test Plan:
- Reset -> o_r/g/b=0, o_pos_ready=1, o_rom_addr=0; bg 8'h20 at any x,y -> output 8'h20/20/20 two cycles after reset release.
- Load (100,50,en=1); frame_start; sweep y=50, x=99..101; ROM returns 24'h123456 -> addr 0 at x=100, 1 at x=101; outputs bg, 12/34/56, 12/34/56 with 2-cycle lag.
- Card at (100,50); x=163,y=145 -> addr 6143 and hit; x=164 -> no hit, addr 0, bg out; y=146 -> no hit.
- Card at (100,50); ROM returns 24'hFF00FF at hit pixel -> background passes through unchanged.
- Request (200,10) mid-frame -> o_pos_ready=0, o_busy=1; second request ignored; old card still drawn until frame_start; afterwards new position drawn and o_pos_ready=1.
- Request with o_pos_ready=1 and frame_start same cycle -> active unchanged this frame, committed next frame_start; separately, px=620 -> x=639 gives addr 19 and no wrap to x=0. Assert i_rst_n mid-line -> outputs 0 and pending cleared.
